// File: rtl/spectrum_bar_writer.sv
// spectrum_bar_writer: renders one frame-buffer column per accepted bar, with a decaying peak-hold marker
module spectrum_bar_writer #(
  parameter int COL_BW = 6,
  parameter int DECAY_FRAMES = 4,
  parameter int DECAY_BW = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [6:0]        Bar,
  input  logic              FrameStart,
  output logic              Busy,
  output logic              Done,
  output logic              WrEn,
  output logic [COL_BW+6:0] WrAddr,
  output logic [1:0]        WrData
);
  localparam int COLUMNS = 2**COL_BW;
  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
  state_t state_q, state_d;
  logic [COL_BW-1:0] col_q, col_d;
  logic [6:0] row_q, row_d, bar_q, bar_d;
  logic [6:0] peak_q [COLUMNS];
  logic [6:0] peak_d [COLUMNS];
  logic [DECAY_BW-1:0] dcnt_q, dcnt_d;
  logic decay_q, decay_d, pend_q, pend_d, done_q, done_d;
  logic [6:0] p, pd, np, wp;
  logic apply, wrap;
  // State register; reset aborts any sweep and clears the peak memory
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      bar_q <= '0;
      dcnt_q <= '0;
      decay_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < COLUMNS; i++) peak_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      bar_q <= bar_d;
      dcnt_q <= dcnt_d;
      decay_q <= decay_d;
      pend_q <= pend_d;
      done_q <= done_d;
      peak_q <= peak_d;
    end
  end
  // Next-state: sweep sequencing, peak update, frame application (immediate in IDLE, deferred while busy)
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    bar_d = bar_q;
    dcnt_d = dcnt_q;
    decay_d = decay_q;
    pend_d = pend_q | (FrameStart && state_q != IDLE);
    done_d = 1'b0;
    peak_d = peak_q;
    apply = 1'b0;
    p = peak_q[col_q];
    pd = (decay_q && p != 7'd0) ? p - 7'd1 : p;
    np = (bar_q > pd) ? bar_q : pd;
    unique case (state_q)
      IDLE: begin
        apply = FrameStart;
        if (Start) begin
          state_d = CALC;
          bar_d = Bar;
        end
      end
      CALC: begin
        peak_d[col_q] = np;
        row_d = '0;
        state_d = WRITE;
      end
      WRITE: begin
        row_d = row_q + 7'd1;
        if (row_q == 7'd127) begin
          state_d = IDLE;
          done_d = 1'b1;
          col_d = col_q + COL_BW'(1);
          apply = pend_q | FrameStart;
        end
      end
      default: state_d = IDLE;
    endcase
    wrap = dcnt_q == DECAY_BW'(DECAY_FRAMES - 1);
    if (apply) begin
      col_d = '0;
      pend_d = 1'b0;
      dcnt_d = wrap ? '0 : dcnt_q + DECAY_BW'(1);
      decay_d = wrap;
    end
  end
  // Pixel stream: bar below rBar, marker one row under the stored peak when it rises above the bar
  always_comb begin
    wp = peak_q[col_q];
    Busy = state_q != IDLE;
    Done = done_q;
    WrEn = state_q == WRITE;
    WrAddr = WrEn ? {col_q, row_q} : '0;
    WrData = !WrEn ? 2'b00 : (row_q < bar_q) ? 2'b01 : (wp > bar_q && row_q == wp - 7'd1) ? 2'b10 : 2'b00;
  end
endmodule

// File: tb/tb_spectrum_bar_writer.sv
// tb_spectrum_bar_writer: directed scoreboard bench for spectrum_bar_writer
module tb_spectrum_bar_writer;
  localparam int COL_BW = 6;
  logic Clock = 0, Reset = 1, Start = 0, FrameStart = 0;
  logic [6:0] Bar = 0;
  logic Busy, Done, WrEn;
  logic [COL_BW+6:0] WrAddr;
  logic [1:0] WrData;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int peak_m [64];
  int col_m = 0, dcnt_m = 0;
  bit decay_m = 0;

  spectrum_bar_writer #(.COL_BW(COL_BW), .DECAY_FRAMES(4), .DECAY_BW(2)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Bar(Bar), .FrameStart(FrameStart),
    .Busy(Busy), .Done(Done), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write is popped against the scoreboard; a write with nothing expected is a miscompare
  always @(negedge Clock) begin
    if (WrEn !== 1'b0) begin
      if (exp_q.size() == 0) check("extra_write", {17'd0, WrAddr, WrData}, 32'h7fff_ffff);
      else begin
        e = exp_q.pop_front();
        check("write", {17'd0, WrAddr, WrData}, e);
      end
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic model_frame;
    col_m = 0;
    dcnt_m = (dcnt_m == 3) ? 0 : dcnt_m + 1;
    decay_m = (dcnt_m == 0);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 64; i++) peak_m[i] = 0;
    col_m = 0;
    dcnt_m = 0;
    decay_m = 0;
  endtask

  task automatic push_col(input int b);
    int p, pd, np, d;
    p = peak_m[col_m];
    pd = (decay_m && p > 0) ? p - 1 : p;
    np = (b > pd) ? b : pd;
    peak_m[col_m] = np;
    for (int r = 0; r < 128; r++) begin
      d = (r < b) ? 1 : (np > b && r == np - 1) ? 2 : 0;
      exp_q.push_back(32'((col_m << 9) | (r << 2) | d));
    end
  endtask

  task automatic frame;
    FrameStart = 1;
    tick;
    FrameStart = 0;
    model_frame();
  endtask

  // One column: Start at cycle 0, optional stray Start / FrameStart / Reset at given sweep cycles
  task automatic sweep(input int b, input bit fs_same, input int st_at, input int fs_at, input int rst_at);
    bit pend = 0;
    if (fs_same) begin
      FrameStart = 1;
      model_frame();
    end
    push_col(b);
    Start = 1;
    Bar = 7'(b);
    tick;
    Start = 0;
    FrameStart = 0;
    Bar = 7'($urandom);
    for (int c = 1; c <= 129; c++) begin
      if (c == rst_at) begin
        Reset = 1;
        #1;
        check("rst_wren", {31'd0, WrEn}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        exp_q.delete();
        model_reset();
        tick;
        Reset = 0;
        return;
      end
      check("busy", {31'd0, Busy}, 1);
      if (c == st_at) Start = 1;
      if (c == fs_at) begin
        FrameStart = 1;
        pend = 1;
      end
      tick;
      Start = 0;
      FrameStart = 0;
    end
    check("done", {31'd0, Done}, 1);
    check("busy_end", {31'd0, Busy}, 0);
    check("drained", exp_q.size(), 0);
    col_m = (col_m + 1) % 64;
    if (pend) model_frame();
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_outs", {15'd0, Busy, Done, WrEn, WrAddr, WrData}, 0);
    repeat (3) tick;
    Reset = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      check("idle_outs", {15'd0, Busy, Done, WrEn, WrAddr, WrData}, 0);
    end
    sweep(10, 0, 0, 0, 0);
    frame();
    sweep(3, 0, 0, 0, 0);
    repeat (3) frame();
    sweep(3, 0, 0, 0, 0);
    sweep(5, 0, 50, 60, 0);
    sweep(127, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) sweep(127, 0, 0, 0, 0);
    sweep(20, 0, 0, 0, 70);
    repeat (4) tick;
    check("post_reset_idle", {30'd0, Busy, WrEn}, 0);
    sweep(0, 0, 0, 0, 0);
    repeat (5) tick;
    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
